// File: rtl/block_spawn_scheduler.sv
// Falling-block spawn scheduler.
// One step per frame clock. The scheduler releases block slots at a fixed,
// level-dependent spacing onto random X columns. It recycles slots whose
// block falls off screen or hits the player, and it tracks lives and levels.
module block_spawn_scheduler #(
  parameter int N_SLOTS      = 4,
  parameter int LEVEL_BLOCKS = 16,
  parameter int GAP_INIT     = 60,
  parameter int GAP_STEP     = 8,
  parameter int GAP_MIN      = 16,
  parameter int X_MIN        = 40,
  parameter int LIVES_INIT   = 3
) (
  input  logic                   i_frame_clk,
  input  logic                   i_reset,
  input  logic                   i_restart,
  input  logic                   i_start,
  input  logic [N_SLOTS-1:0]     i_block_collision,
  input  logic [N_SLOTS-1:0]     i_block_end,
  output logic [N_SLOTS-1:0]     o_block_ready,
  output logic [N_SLOTS-1:0]     o_block_reset,
  output logic [10*N_SLOTS-1:0]  o_block_x_center,
  output logic [1:0]             o_lives,
  output logic [3:0]             o_level,
  output logic                   o_level_done,
  output logic                   o_game_over
);

  localparam int SW = $clog2(LEVEL_BLOCKS + 1);
  localparam int GW = $clog2(GAP_INIT + 1);
  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LEVEL_DONE, S_GAME_OVER} state_t;

  state_t                    r_state,      w_state;
  logic [N_SLOTS-1:0]        r_busy,       w_busy;
  logic [N_SLOTS-1:0]        r_blk_rst,    w_blk_rst;
  logic [N_SLOTS-1:0][9:0]   r_x,          w_x;
  logic [1:0]                r_lives,      w_lives;
  logic [3:0]                r_level,      w_level;
  logic [GW-1:0]             r_gap_reload, w_gap_reload;
  logic [GW-1:0]             r_gap_cnt,    w_gap_cnt;
  logic [SW-1:0]             r_spawned,    w_spawned;
  logic [9:0]                r_lfsr,       w_lfsr;

  logic [N_SLOTS-1:0]        w_hit, w_ret;
  logic [7:0]                w_hits;
  logic [1:0]                w_lives_dec;
  logic [IW-1:0]             w_idx;
  logic                      w_found;
  logic [9:0]                w_rand;

  // Next-state and datapath: retire, lives, release, and level/game transitions
  always_comb begin
    w_state      = r_state;
    w_busy       = r_busy;
    w_blk_rst    = '0;
    w_x          = r_x;
    w_lives      = r_lives;
    w_level      = r_level;
    w_gap_reload = r_gap_reload;
    w_gap_cnt    = r_gap_cnt;
    w_spawned    = r_spawned;
    w_lfsr       = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

    // Only busy slots react to their flags; collision wins over end for lives.
    w_hit  = r_busy & i_block_collision;
    w_ret  = r_busy & (i_block_collision | i_block_end);
    w_rand = 10'(X_MIN) + {1'b0, r_lfsr[8:0]};

    w_hits = '0;
    for (int i = 0; i < N_SLOTS; i++) w_hits = w_hits + 8'(w_hit[i]);
    if ({6'b0, r_lives} <= w_hits) w_lives_dec = '0;
    else                           w_lives_dec = r_lives - w_hits[1:0];

    // Lowest-index slot that was free at the start of the cycle. A slot
    // retired this cycle is still busy here, so it waits one frame.
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_idx   = IW'(i);
        w_found = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state   = S_PLAY;
          w_gap_cnt = '0;
          w_spawned = '0;
        end
      end
      S_PLAY: begin
        w_busy    = r_busy & ~w_ret;
        w_blk_rst = w_ret;
        w_lives   = w_lives_dec;
        if (w_hits != 8'd0 && w_lives_dec == 2'd0) begin
          // Out of lives: abandon every slot still on screen.
          w_state   = S_GAME_OVER;
          w_blk_rst = r_busy;
          w_busy    = '0;
        end else if (r_spawned == SW'(LEVEL_BLOCKS) && r_busy == '0) begin
          w_state = S_LEVEL_DONE;
        end else if (r_gap_cnt == '0 && r_spawned < SW'(LEVEL_BLOCKS) && w_found) begin
          w_busy[w_idx] = 1'b1;
          w_x[w_idx]    = w_rand;
          w_spawned     = r_spawned + SW'(1);
          w_gap_cnt     = r_gap_reload - GW'(1);
        end else if (r_gap_cnt != '0) begin
          w_gap_cnt = r_gap_cnt - GW'(1);
        end
      end
      S_LEVEL_DONE: begin
        if (i_start) begin
          w_state   = S_PLAY;
          w_spawned = '0;
          w_gap_cnt = '0;
          if (r_level != 4'd15) w_level = r_level + 4'd1;
          if (r_gap_reload >= GW'(GAP_MIN + GAP_STEP)) w_gap_reload = r_gap_reload - GW'(GAP_STEP);
          else                                         w_gap_reload = GW'(GAP_MIN);
        end
      end
      default: ; // GAME_OVER holds until restart
    endcase
  end

  // State register; reset and restart both reinitialise the whole game
  always_ff @(posedge i_frame_clk) begin
    if (i_reset || i_restart) begin
      r_state      <= S_IDLE;
      r_busy       <= '0;
      r_blk_rst    <= '1;
      r_x          <= {N_SLOTS{10'(X_MIN)}};
      r_lives      <= 2'(LIVES_INIT);
      r_level      <= 4'd1;
      r_gap_reload <= GW'(GAP_INIT);
      r_gap_cnt    <= '0;
      r_spawned    <= '0;
      r_lfsr       <= 10'h001;
    end else begin
      r_state      <= w_state;
      r_busy       <= w_busy;
      r_blk_rst    <= w_blk_rst;
      r_x          <= w_x;
      r_lives      <= w_lives;
      r_level      <= w_level;
      r_gap_reload <= w_gap_reload;
      r_gap_cnt    <= w_gap_cnt;
      r_spawned    <= w_spawned;
      r_lfsr       <= w_lfsr;
    end
  end

  assign o_block_ready    = r_busy;
  assign o_block_reset    = r_blk_rst;
  assign o_block_x_center = r_x;
  assign o_lives          = r_lives;
  assign o_level          = r_level;
  assign o_level_done     = (r_state == S_LEVEL_DONE);
  assign o_game_over      = (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_block_spawn_scheduler.sv
// Bench for block_spawn_scheduler: scenario tasks with inline checks, plus a
// release scoreboard (slot, X) checked whenever a ready bit rises.
module tb_block_spawn_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0, restart = 1'b0, start = 1'b0;
  logic [N-1:0]  col = '0, bend = '0;
  logic [N-1:0]  ready, brst;
  logic [10*N-1:0] xc;
  logic [1:0]    lives;
  logic [3:0]    level;
  logic          ldone, gover;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  block_spawn_scheduler dut (
    .i_frame_clk(clk), .i_reset(reset), .i_restart(restart), .i_start(start),
    .i_block_collision(col), .i_block_end(bend),
    .o_block_ready(ready), .o_block_reset(brst), .o_block_x_center(xc),
    .o_lives(lives), .o_level(level), .o_level_done(ldone), .o_game_over(gover)
  );

  // Reference LFSR, kept in lockstep with the game clock
  logic [9:0] m_lfsr = 10'h001;
  always @(posedge clk) begin
    if (reset || restart) m_lfsr <= 10'h001;
    else                  m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  typedef struct { int slot; logic [9:0] x; } rel_t;
  rel_t q[$];

  // Release monitor: each newly-raised ready bit must match the next expected release
  logic [N-1:0] prev_ready = '0;
  rel_t mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ready[i] === 1'b1 && prev_ready[i] !== 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_release slot=%0d got x=%0d expected none", i, xc[10*i +: 10]);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.slot != i || xc[10*i +: 10] !== mon_e.x) begin
            n_fail++;
            $display("FAIL release got slot=%0d x=%0d expected slot=%0d x=%0d", i, xc[10*i +: 10], mon_e.slot, mon_e.x);
          end
        end
      end
    end
    prev_ready = ready;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just before the edge on which the release should happen
  task automatic expect_release(input int slot);
    rel_t e;
    e.slot = slot;
    e.x = 10'd40 + {1'b0, m_lfsr[8:0]};
    q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; step(1);
    if (ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", ready); end n_chk++;
    if (brst !== 4'b1111) begin n_fail++; $display("FAIL rst_breset got=%b exp=1111", brst); end n_chk++;
    if (xc !== {4{10'd40}}) begin n_fail++; $display("FAIL rst_x got=%h exp=%h", xc, {4{10'd40}}); end n_chk++;
    if (lives !== 2'd3) begin n_fail++; $display("FAIL rst_lives got=%0d exp=3", lives); end n_chk++;
    if (level !== 4'd1) begin n_fail++; $display("FAIL rst_level got=%0d exp=1", level); end n_chk++;
    if (ldone !== 1'b0 || gover !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b exp=00", ldone, gover); end n_chk++;
    reset = 1'b0; step(1);
    if (brst !== 4'b0000) begin n_fail++; $display("FAIL rst_pulse_len got=%b exp=0000", brst); end n_chk++;
  endtask

  task automatic test_first_release();
    start = 1'b1; step(1); start = 1'b0;
    if (ready !== 4'b0000) begin n_fail++; $display("FAIL enter_play_ready got=%b exp=0000", ready); end n_chk++;
    expect_release(0); step(1);
    if (ready !== 4'b0001) begin n_fail++; $display("FAIL first_ready got=%b exp=0001", ready); end n_chk++;
    if (xc[9:0] !== 10'd44) begin n_fail++; $display("FAIL first_x got=%0d exp=44", xc[9:0]); end n_chk++;
    step(59);
    if (ready !== 4'b0001) begin n_fail++; $display("FAIL gap59_ready got=%b exp=0001", ready); end n_chk++;
    expect_release(1); step(1);
    if (ready !== 4'b0011) begin n_fail++; $display("FAIL gap60_ready got=%b exp=0011", ready); end n_chk++;
  endtask

  task automatic test_full_hold();
    step(59); expect_release(2); step(1);
    step(59); expect_release(3); step(1);
    if (ready !== 4'b1111) begin n_fail++; $display("FAIL fill_ready got=%b exp=1111", ready); end n_chk++;
    step(70);
    if (ready !== 4'b1111 || brst !== 4'b0000) begin n_fail++; $display("FAIL hold got=%b/%b exp=1111/0000", ready, brst); end n_chk++;
    bend = 4'b0100; step(1); bend = '0;
    if (brst !== 4'b0100) begin n_fail++; $display("FAIL end2_breset got=%b exp=0100", brst); end n_chk++;
    if (ready !== 4'b1011) begin n_fail++; $display("FAIL end2_ready got=%b exp=1011", ready); end n_chk++;
    if (lives !== 2'd3) begin n_fail++; $display("FAIL end2_lives got=%0d exp=3", lives); end n_chk++;
    expect_release(2); step(1);
    if (ready !== 4'b1111 || brst !== 4'b0000) begin n_fail++; $display("FAIL rerelease got=%b/%b exp=1111/0000", ready, brst); end n_chk++;
  endtask

  task automatic test_two_hits();
    col = 4'b0101; step(1); col = '0;
    if (lives !== 2'd1) begin n_fail++; $display("FAIL two_hits_lives got=%0d exp=1", lives); end n_chk++;
    if (brst !== 4'b0101) begin n_fail++; $display("FAIL two_hits_breset got=%b exp=0101", brst); end n_chk++;
    if (ready !== 4'b1010 || gover !== 1'b0) begin n_fail++; $display("FAIL two_hits_ready got=%b go=%b exp=1010 go=0", ready, gover); end n_chk++;
  endtask

  task automatic test_both_flags_game_over();
    col = 4'b0010; bend = 4'b0010; step(1); col = '0; bend = '0;
    if (lives !== 2'd0) begin n_fail++; $display("FAIL both_lives got=%0d exp=0", lives); end n_chk++;
    if (brst !== 4'b1010) begin n_fail++; $display("FAIL go_breset got=%b exp=1010", brst); end n_chk++;
    if (ready !== 4'b0000 || gover !== 1'b1) begin n_fail++; $display("FAIL go_state got=%b go=%b exp=0000 go=1", ready, gover); end n_chk++;
    step(1);
    if (brst !== 4'b0000) begin n_fail++; $display("FAIL go_pulse_len got=%b exp=0000", brst); end n_chk++;
    start = 1'b1; step(3); start = 1'b0;
    if (gover !== 1'b1 || ready !== 4'b0000 || lives !== 2'd0) begin n_fail++; $display("FAIL go_start_ignored got=%b/%b/%0d exp=1/0000/0", gover, ready, lives); end n_chk++;
    restart = 1'b1; step(1); restart = 1'b0;
    if (gover !== 1'b0 || lives !== 2'd3 || level !== 4'd1) begin n_fail++; $display("FAIL restart got=%b/%0d/%0d exp=0/3/1", gover, lives, level); end n_chk++;
    if (brst !== 4'b1111 || xc !== {4{10'd40}}) begin n_fail++; $display("FAIL restart_slots got=%b/%h exp=1111/%h", brst, xc, {4{10'd40}}); end n_chk++;
    step(1);
  endtask

  task automatic test_levels();
    int g;
    int exp_lv;
    start = 1'b1; step(1); start = 1'b0;
    for (int lv = 1; lv <= 16; lv++) begin
      g = 60 - 8 * (lv - 1);
      if (g < 16) g = 16;
      exp_lv = (lv > 15) ? 15 : lv;
      if (level !== 4'(exp_lv)) begin n_fail++; $display("FAIL level got=%0d exp=%0d", level, exp_lv); end n_chk++;
      for (int b = 0; b < 16; b++) begin
        expect_release(0); step(1);
        if (ready !== 4'b0001) begin n_fail++; $display("FAIL lv%0d_b%0d_ready got=%b exp=0001", lv, b, ready); end n_chk++;
        bend = 4'b0001; step(1); bend = '0;
        if (brst !== 4'b0001 || ready !== 4'b0000) begin n_fail++; $display("FAIL lv%0d_b%0d_retire got=%b/%b exp=0001/0000", lv, b, brst, ready); end n_chk++;
        if (b < 15) step(g - 2);
      end
      if (ldone !== 1'b0) begin n_fail++; $display("FAIL lv%0d_early_done got=%b exp=0", lv, ldone); end n_chk++;
      step(1);
      if (ldone !== 1'b1 || ready !== 4'b0000) begin n_fail++; $display("FAIL lv%0d_done got=%b/%b exp=1/0000", lv, ldone, ready); end n_chk++;
      if (lv < 16) begin
        start = 1'b1; step(1); start = 1'b0;
        if (ldone !== 1'b0) begin n_fail++; $display("FAIL lv%0d_advance got=%b exp=0", lv, ldone); end n_chk++;
      end
    end
  endtask

  task automatic test_reset_mid_play();
    restart = 1'b1; step(1); restart = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    expect_release(0); step(1);
    step(59); expect_release(1); step(1);
    step(59); expect_release(2); step(1);
    if (ready !== 4'b0111) begin n_fail++; $display("FAIL mid_fill got=%b exp=0111", ready); end n_chk++;
    reset = 1'b1; step(1); reset = 1'b0;
    if (ready !== 4'b0000 || brst !== 4'b1111) begin n_fail++; $display("FAIL mid_reset got=%b/%b exp=0000/1111", ready, brst); end n_chk++;
    if (lives !== 2'd3 || level !== 4'd1 || ldone !== 1'b0 || gover !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state got=%0d/%0d/%b/%b exp=3/1/0/0", lives, level, ldone, gover); end n_chk++;
    step(1);
    if (brst !== 4'b0000 || ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_idle got=%b/%b exp=0000/0000", brst, ready); end n_chk++;
    start = 1'b1; step(1); start = 1'b0;
    expect_release(0); step(1);
    if (xc[9:0] !== 10'd44) begin n_fail++; $display("FAIL lfsr_reseed_x got=%0d exp=44", xc[9:0]); end n_chk++;
  endtask

  initial begin
    step(2);
    test_reset();
    test_first_release();
    test_full_hold();
    test_two_hits();
    test_both_flags_game_over();
    test_levels();
    test_reset_mid_play();
    step(2);
    if (q.size() != 0) begin n_fail++; $display("FAIL release_queue got=%0d pending exp=0", q.size()); end n_chk++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
